// File: rtl/mac_col_ctrl_if.sv
// mac_col_ctrl_if: handshake and psum bus of one MAC column controller.
//   w_valid/w_ready/w_load       weight vector handshake and column weight-register enable
//   x_valid/x_ready/x_load       activation vector handshake and column fire strobe
//   psum_valid/psum_last/psum_idx  result qualifiers aligned to the MAC pipeline output
// Modports: slave = controller side, master = fetch logic / psum writer side.
interface mac_col_ctrl_if #(
    parameter int unsigned CW = 8
);
    logic          w_valid;
    logic          w_ready;
    logic          w_load;
    logic          x_valid;
    logic          x_ready;
    logic          x_load;
    logic          psum_valid;
    logic          psum_last;
    logic [CW-1:0] psum_idx;

    modport slave (
        input  w_valid, x_valid,
        output w_ready, w_load, x_ready, x_load, psum_valid, psum_last, psum_idx
    );

    modport master (
        output w_valid, x_valid,
        input  w_ready, w_load, x_ready, x_load, psum_valid, psum_last, psum_idx
    );
endinterface

// File: rtl/mac_col_ctrl.sv
// mac_col_ctrl: sequencer for one column of 8-input signed MAC units.
// Per job loads one weight vector, streams num_vec activation vectors, and tags
// each MAC result with valid/last/index aligned to the LAT-cycle MAC pipeline.
// Ports:
//   clk, reset      single clock, synchronous active-high reset
//   start, num_vec  job request (sampled in IDLE) and vector count
//   bus             mac_col_ctrl_if.slave: weight/activation handshakes, psum tags
//   mac_reset       MAC register reset, high only in reset and IDLE
//   busy, done      job in progress / one-cycle end-of-job pulse
//   stall_cnt       EXEC cycles without x_valid
// Optional feature: define MAC_COL_CTRL_PERF_EN to build the saturating stall
// counter; otherwise stall_cnt is tied to zero.
module mac_col_ctrl #(
    parameter int unsigned LAT = 2,
    parameter int unsigned CW  = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [CW-1:0]   num_vec,
    mac_col_ctrl_if.slave   bus,
    output logic            mac_reset,
    output logic            busy,
    output logic            done,
    output logic [15:0]     stall_cnt
);

    localparam int unsigned SCW = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD_W = 2'd1,
        EXEC   = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] num_q, num_d;
    logic [CW-1:0] vcnt_q, vcnt_d;
    logic          w_ready_q, w_ready_d;
    logic          x_ready_q, x_ready_d;
    logic          mac_reset_q, mac_reset_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [LAT-1:0] vld_q, vld_d;
    logic [LAT-1:0] last_q, last_d;
    logic [CW-1:0]  idx_q [LAT];
    logic [CW-1:0]  idx_d [LAT];
    logic          w_load_c, x_load_c, final_c;

    // Handshake fire strobes double as the column register enables.
    assign w_load_c = bus.w_valid & w_ready_q;
    assign x_load_c = bus.x_valid & x_ready_q;

    // Next-state, counters, delay-line shift and registered-output decode.
    always_comb begin
        state_d = state_q;
        num_d   = num_q;
        vcnt_d  = vcnt_q;
        final_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    num_d   = num_vec;
                    vcnt_d  = '0;
                    state_d = (num_vec == '0) ? DRAIN : LOAD_W;
                end
            end
            LOAD_W: begin
                if (w_load_c) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (x_load_c) begin
                    vcnt_d = vcnt_q + CW'(1);
                    if (vcnt_q == num_q - CW'(1)) begin
                        final_c = 1'b1;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (done_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Tag pipeline mirrors the MAC datapath: one stage per MAC register.
        vld_d[0]  = x_load_c;
        last_d[0] = x_load_c & final_c;
        idx_d[0]  = vcnt_q;
        for (int i = 1; i < int'(LAT); i++) begin
            vld_d[i]  = vld_q[i-1];
            last_d[i] = last_q[i-1];
            idx_d[i]  = idx_q[i-1];
        end

        w_ready_d   = (state_d == LOAD_W);
        x_ready_d   = (state_d == EXEC);
        mac_reset_d = (state_d == IDLE);
        busy_d      = (state_d != IDLE);
        // Pulse once the delay line will be empty next cycle; never in the
        // first DRAIN cycle, so an empty job still spends one cycle draining.
        done_d      = (state_q == DRAIN) && !done_q && (vld_d == '0);
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            num_q       <= '0;
            vcnt_q      <= '0;
            w_ready_q   <= 1'b0;
            x_ready_q   <= 1'b0;
            mac_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            vld_q       <= '0;
            last_q      <= '0;
            for (int i = 0; i < int'(LAT); i++) begin
                idx_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            num_q       <= num_d;
            vcnt_q      <= vcnt_d;
            w_ready_q   <= w_ready_d;
            x_ready_q   <= x_ready_d;
            mac_reset_q <= mac_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            vld_q       <= vld_d;
            last_q      <= last_d;
            for (int i = 0; i < int'(LAT); i++) begin
                idx_q[i] <= idx_d[i];
            end
        end
    end

`ifdef MAC_COL_CTRL_PERF_EN
    logic [SCW-1:0] stall_q, stall_d;

    // Saturating count of starved EXEC cycles, cleared per accepted job.
    always_comb begin
        stall_d = stall_q;
        if ((state_q == IDLE) && start) begin
            stall_d = '0;
        end else if ((state_q == EXEC) && !bus.x_valid && (stall_q != '1)) begin
            stall_d = stall_q + SCW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = SCW'(0);
`endif

    assign bus.w_ready    = w_ready_q;
    assign bus.x_ready    = x_ready_q;
    assign bus.w_load     = w_load_c;
    assign bus.x_load     = x_load_c;
    assign bus.psum_valid = vld_q[LAT-1];
    assign bus.psum_last  = last_q[LAT-1];
    assign bus.psum_idx   = idx_q[LAT-1];
    assign mac_reset      = mac_reset_q;
    assign busy           = busy_q;
    assign done           = done_q;

endmodule
